// File: rtl/cache_pkg.sv
// Shared types, sizes and the byte-merge helper for the data cache.
package cache_pkg;

    localparam int NUM_LINES  = 4;
    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int TAG_W      = 32 - IDX_W - OFF_W - 2;
    localparam int LINE_BITS  = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    // Big-endian lanes: lane 0 is the most significant byte.
    function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                               input logic [7:0]  data,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[31:24] = data;
            2'd1:    res[23:16] = data;
            2'd2:    res[15:8]  = data;
            default: res[7:0]   = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// Latency: combinational read by index, writes take effect at the next clock edge.
// Backpressure: none; the controller serialises all writes.
module dcache_array
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     idx,
    output logic [TAG_W-1:0]     tagRd,
    output logic                 validRd,
    output logic                 dirtyRd,
    output logic [LINE_BITS-1:0] lineRd,
    input  logic                 lineWe,
    input  logic [TAG_W-1:0]     lineTag,
    input  logic [LINE_BITS-1:0] lineData,
    input  logic                 wordWe,
    input  logic [OFF_W-1:0]     wordOff,
    input  logic [31:0]          wordData,
    input  logic                 clrDirty
);

    logic [TAG_W-1:0]     tagMem  [NUM_LINES];
    logic [LINE_BITS-1:0] dataMem [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    assign tagRd   = tagMem[idx];
    assign validRd = valid[idx];
    assign dirtyRd = dirty[idx];
    assign lineRd  = dataMem[idx];

    // Tag and data contents are deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (lineWe) begin
            dataMem[idx] <= lineData;
            tagMem[idx]  <= lineTag;
        end else if (wordWe) begin
            dataMem[idx][{wordOff, 5'b0} +: 32] <= wordData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (lineWe) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wordWe) begin
            dirty[idx] <= 1'b1;
        end else if (clrDirty) begin
            dirty[idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller for the M stage.
// Latency: hits in zero cycles; misses stall for one cycle plus each line transfer.
// Backpressure: dhit=0 freezes the core until the line is installed.
module dcache_ctrl
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic                 req_byte,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic [31:0]          rdata,
    output logic                 dhit,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    state_t               state, nextState;
    logic [TAG_W-1:0]     reqTag, missTag, fillTag, tagRd;
    logic [IDX_W-1:0]     reqIdx, missIdx, arrIdx;
    logic [OFF_W-1:0]     reqWord;
    logic                 validRd, dirtyRd, hit;
    logic [LINE_BITS-1:0] lineRd;
    logic [31:0]          curWord, wordData;
    logic                 lineWe, wordWe, clrDirty;

    assign reqTag  = req_addr[31:IDX_W+OFF_W+2];
    assign reqIdx  = req_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign reqWord = req_addr[OFF_W+1:2];

    // Mid-miss the array is addressed by the latched miss, never the live request.
    assign arrIdx  = (state == IDLE) ? reqIdx : missIdx;
    assign fillTag = (state == IDLE) ? reqTag : missTag;
    assign curWord = lineRd[{reqWord, 5'b0} +: 32];
    assign hit     = req_valid & validRd & (tagRd == reqTag);
    assign rdata   = validRd ? curWord : 32'h0;

    dcache_array u_arr (
        .clk      (clk),
        .reset    (reset),
        .idx      (arrIdx),
        .tagRd    (tagRd),
        .validRd  (validRd),
        .dirtyRd  (dirtyRd),
        .lineRd   (lineRd),
        .lineWe   (lineWe),
        .lineTag  (missTag),
        .lineData (mem_rdata),
        .wordWe   (wordWe),
        .wordOff  (reqWord),
        .wordData (wordData),
        .clrDirty (clrDirty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (req_valid && !hit) nextState = (validRd && dirtyRd) ? WB : FILL;
            WB:   if (mem_ack) nextState = FILL;
            FILL: if (mem_ack) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Writes are masked during reset so a coincident ack cannot install a line.
    always_comb begin
        dhit     = 1'b0;
        lineWe   = 1'b0;
        wordWe   = 1'b0;
        clrDirty = 1'b0;
        wordData = req_byte ? byte_merge(curWord, req_wdata[7:0], req_addr[1:0]) : req_wdata;
        case (state)
            IDLE: begin
                dhit   = ~req_valid | hit;
                wordWe = hit & req_we & ~reset;
            end
            WB:   clrDirty = mem_ack & ~reset;
            FILL: lineWe   = mem_ack & ~reset;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            missTag <= '0;
            missIdx <= '0;
        end else if (state == IDLE && req_valid && !hit) begin
            missTag <= reqTag;
            missIdx <= reqIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (nextState != IDLE);
            mem_we  <= (nextState == WB);
            if (nextState == WB) begin
                mem_addr  <= {tagRd, arrIdx, {(OFF_W+2){1'b0}}};
                mem_wdata <= lineRd;
            end else if (nextState == FILL) begin
                mem_addr  <= {fillTag, arrIdx, {(OFF_W+2){1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, store hits, dirty eviction, reset mid-fill, idle stability.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_we, req_byte;
    logic [31:0]  req_addr, req_wdata;
    logic [31:0]  rdata;
    logic         dhit;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] LINE1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE2 = 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001;
    localparam logic [127:0] LINE3 = 128'h55550004_55550003_55550002_55550001;
    localparam logic [127:0] LINE4 = 128'h77770004_77770003_77770002_77770001;

    always #5 clk = ~clk;

    dcache_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic we, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_byte  = b;
        req_addr  = a;
        req_wdata = d;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        req(0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_dhit", dhit, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata_invalid", rdata, 0);

        // Cold load 0x40: mem_req in the three cycles after the miss, ack on the third.
        req(1, 0, 0, 32'h40, 32'h0);
        chk("cold_c0_dhit", dhit, 0);
        tick();
        chk("cold_c1_req", mem_req, 1);
        chk("cold_c1_addr", mem_addr, 32'h40);
        chk("cold_c1_we", mem_we, 0);
        chk("cold_c1_dhit", dhit, 0);
        tick();
        chk("cold_c2_req", mem_req, 1);
        chk("cold_c2_dhit", dhit, 0);
        tick();
        chk("cold_c3_req", mem_req, 1);
        mem_rdata = LINE1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("cold_hit_dhit", dhit, 1);
        chk("cold_hit_rdata", rdata, 32'h11111111);
        chk("cold_req_drop", mem_req, 0);
        req(1, 0, 0, 32'h48, 32'h0);
        chk("cold_word2", rdata, 32'h33333333);

        // Byte store to lane 1 of word 0, then a word store to word 1.
        req(1, 1, 1, 32'h41, 32'hDEADBEAB);
        chk("bst_dhit", dhit, 1);
        tick();
        req(1, 1, 0, 32'h44, 32'hCAFEF00D);
        chk("wst_dhit", dhit, 1);
        tick();
        req(1, 0, 0, 32'h40, 32'h0);
        chk("bst_rdata", rdata, 32'h11AB1111);
        chk("bst_no_mem", mem_req, 0);
        chk("bst_dirty", u_dut.u_arr.dirty[0], 1);
        req(1, 0, 0, 32'h44, 32'h0);
        chk("wst_rdata", rdata, 32'hCAFEF00D);

        // Conflict miss at 0x140 evicts the dirty line at 0x40.
        req(1, 0, 0, 32'h140, 32'h0);
        chk("wb_c0_dhit", dhit, 0);
        tick();
        chk("wb_req", mem_req, 1);
        chk("wb_we", mem_we, 1);
        chk("wb_addr", mem_addr, 32'h40);
        chk("wb_wdata_lo", mem_wdata[63:0], 64'hCAFEF00D_11AB1111);
        chk("wb_dhit", dhit, 0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("fill_req", mem_req, 1);
        chk("fill_we", mem_we, 0);
        chk("fill_addr", mem_addr, 32'h140);
        chk("fill_dhit", dhit, 0);
        chk("wb_dirty_clr", u_dut.u_arr.dirty[0], 0);
        mem_rdata = LINE2;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("evict_dhit", dhit, 1);
        chk("evict_rdata", rdata, 32'hAAAA0001);
        chk("evict_req_drop", mem_req, 0);
        req(1, 0, 0, 32'h14C, 32'h0);
        chk("evict_word3", rdata, 32'hAAAA0004);

        // Ack on the first mem_req cycle: two stall cycles in total.
        req(1, 0, 0, 32'h50, 32'h0);
        chk("fast_c0_dhit", dhit, 0);
        tick();
        chk("fast_req", mem_req, 1);
        chk("fast_addr", mem_addr, 32'h50);
        chk("fast_c1_dhit", dhit, 0);
        mem_rdata = LINE3;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("fast_req_drop", mem_req, 0);
        chk("fast_dhit", dhit, 1);
        chk("fast_rdata", rdata, 32'h55550001);

        // Store miss allocates, then the store lands as a hit.
        req(1, 1, 0, 32'h78, 32'h12345678);
        chk("smiss_c0_dhit", dhit, 0);
        tick();
        chk("smiss_addr", mem_addr, 32'h70);
        chk("smiss_we", mem_we, 0);
        mem_rdata = LINE4;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("smiss_dhit", dhit, 1);
        tick();
        req(1, 0, 0, 32'h78, 32'h0);
        chk("smiss_rdata", rdata, 32'h12345678);
        chk("smiss_dirty", u_dut.u_arr.dirty[3], 1);
        req(1, 0, 0, 32'h74, 32'h0);
        chk("smiss_other_word", rdata, 32'h77770002);

        // Reset in FILL coinciding with mem_ack: nothing installed.
        req(1, 0, 0, 32'h60, 32'h0);
        tick();
        chk("rfill_req", mem_req, 1);
        chk("rfill_addr", mem_addr, 32'h60);
        reset = 1'b1;
        mem_rdata = LINE3;
        mem_ack = 1'b1;
        tick();
        reset = 1'b0;
        mem_ack = 1'b0;
        req(0, 0, 0, 32'h60, 32'h0);
        chk("rfill_req_low", mem_req, 0);
        chk("rfill_dhit", dhit, 1);
        chk("rfill_valid", u_dut.u_arr.valid, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_valid", u_dut.u_arr.valid, 0);
        req(1, 0, 0, 32'h40, 32'h0);
        chk("reload_miss", dhit, 0);
        tick();
        chk("reload_addr", mem_addr, 32'h40);
        chk("reload_we", mem_we, 0);
        mem_rdata = LINE1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("reload_dhit", dhit, 1);
        chk("reload_rdata", rdata, 32'h11111111);

        // Idle cycles with random junk on the request bus.
        for (int i = 0; i < 20; i++) begin
            req(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
            chk("idle_dhit", dhit, 1);
            chk("idle_mem_req", mem_req, 0);
            tick();
        end
        chk("idle_valid", u_dut.u_arr.valid, 4'b0001);
        chk("idle_dirty", u_dut.u_arr.dirty, 4'b0000);
        req(1, 0, 0, 32'h48, 32'h0);
        chk("idle_after_dhit", dhit, 1);
        chk("idle_after_rdata", rdata, 32'h33333333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
